empaquetador_8a32: RTL and testbench

EMPAQUETADOR_8A32 -- requirements
Module: empaquetador_8a32

---
 rtl/empaq_pkg.sv | 24 ++
 rtl/empaq_out_reg.sv | 34 +++
 rtl/empaquetador_8a32.sv | 97 +++++++++
 tb/tb_empaquetador_8a32.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/empaq_pkg.sv
// Shared definitions for the 8-to-32 bit packer: width codes, FSM state type
// and the bytes-per-word helper.
package empaq_pkg;

    localparam logic [1:0] ANCHO_32 = 2'b00;
    localparam logic [1:0] ANCHO_16 = 2'b01;
    localparam logic [1:0] ANCHO_8  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FULL    = 2'b10
    } estado_t;

    // Reserved code 2'b11 falls through to the 8-bit case.
    function automatic logic [2:0] bytes_por_ancho(input logic [1:0] ancho);
        case (ancho)
            ANCHO_32: bytes_por_ancho = 3'd4;
            ANCHO_16: bytes_por_ancho = 3'd2;
            default:  bytes_por_ancho = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/empaq_out_reg.sv
// One-word output holding register with valid/ready handshake; a new word may
// be loaded in the same cycle the current one is consumed.
module empaq_out_reg
    import empaq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        carga,
    input  logic [31:0] palabra,
    input  logic        ready_out,
    output logic [31:0] out_32,
    output logic        valid_out
);

    logic [31:0] word_p1;
    logic        vld_p1;

    // ---- stage p1: registered output word ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_p1 <= 32'h0;
            vld_p1  <= 1'b0;
        end else if (carga) begin
            word_p1 <= palabra;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && ready_out) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_32    = word_p1;
    assign valid_out = vld_p1;

endmodule

// File: rtl/empaquetador_8a32.sv
// Packs MSB-first bytes into 32/16/8-bit words selected by PCLK.
// Optional feature: define EMPAQ_FLUSH_EN to add the flush input.
module empaquetador_8a32
    import empaq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCLK,
    input  logic        ENB,
    input  logic [7:0]  in_8,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [31:0] out_32,
    output logic        valid_out,
    input  logic        ready_out
`ifdef EMPAQ_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    estado_t     estado;
    logic [1:0]  cnt;
    logic [2:0]  n_lat;
    logic [31:0] acc_p0;

    logic        acepta;
    logic [2:0]  n_cur;
    logic        ultimo;
    logic [1:0]  carril;
    logic [31:0] pal_mas;
    logic        carga;
    logic [31:0] palabra;

    // The output register is only ever full in FULL, so ready_in follows it.
    assign ready_in = (estado != FULL) || ready_out;
    assign acepta   = valid_in && ready_in && ENB;

    // Width is sampled on the first byte and frozen for the rest of the word.
    assign n_cur   = (cnt == 2'd0) ? bytes_por_ancho(PCLK) : n_lat;
    assign ultimo  = acepta && (({1'b0, cnt} + 3'd1) == n_cur);
    assign carril  = 2'(n_cur - 3'd1 - {1'b0, cnt});
    assign pal_mas = ((cnt == 2'd0) ? 32'h0 : acc_p0)
                   | ({24'h0, in_8} << {carril, 3'b000});

`ifdef EMPAQ_FLUSH_EN
    always_comb begin
        carga   = ultimo;
        palabra = pal_mas;
        if (flush && estado == COLLECT) begin
            carga   = 1'b1;
            palabra = acepta ? pal_mas : acc_p0;
        end
    end
`else
    assign carga   = ultimo;
    assign palabra = pal_mas;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= IDLE;
            cnt    <= 2'd0;
            n_lat  <= 3'd4;
        end else begin
            if (acepta && cnt == 2'd0)
                n_lat <= n_cur;
            if (carga)
                cnt <= 2'd0;
            else if (acepta)
                cnt <= cnt + 2'd1;
            if (carga)
                estado <= FULL;
            else if (acepta)
                estado <= COLLECT;
            else if (estado == FULL && ready_out)
                estado <= IDLE;
        end
    end

    // ---- stage p0: partial word accumulator ----
    always_ff @(posedge clk) begin
        if (acepta)
            acc_p0 <= pal_mas;
    end

    empaq_out_reg u_out (
        .clk       (clk),
        .reset     (reset),
        .carga     (carga),
        .palabra   (palabra),
        .ready_out (ready_out),
        .out_32    (out_32),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_empaquetador_8a32.sv
// Self-checking bench for empaquetador_8a32: directed scenarios plus random
// traffic against a byte-queue reference model. Honours EMPAQ_FLUSH_EN.
module tb_empaquetador_8a32;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCLK;
    logic        ENB;
    logic [7:0]  in_8;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] out_32;
    logic        valid_out;
    logic        ready_out;
`ifdef EMPAQ_FLUSH_EN
    logic        flush;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    int          m_n;
    bit          m_valid;
    logic [31:0] m_word;

    always #5 clk = ~clk;

    empaquetador_8a32 dut (
        .clk       (clk),
        .reset     (reset),
        .PCLK      (PCLK),
        .ENB       (ENB),
        .in_8      (in_8),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .out_32    (out_32),
        .valid_out (valid_out),
        .ready_out (ready_out)
`ifdef EMPAQ_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    function automatic int n_of(input logic [1:0] p);
        if (p == 2'b00) return 4;
        if (p == 2'b01) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] pack_q();
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'h00;
        for (int i = 0; i < q.size(); i++) b[i] = q[i];
        case (m_n)
            4:       return {b[0], b[1], b[2], b[3]};
            2:       return {16'h0, b[0], b[1]};
            default: return {24'h0, b[0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_step();
        bit acc, had, fl;
        fl = 1'b0;
`ifdef EMPAQ_FLUSH_EN
        fl = flush;
`endif
        acc = valid_in && ENB && (!m_valid || ready_out);
        had = q.size() > 0;
        if (m_valid && ready_out) m_valid = 1'b0;
        if (acc) begin
            if (q.size() == 0) m_n = n_of(PCLK);
            q.push_back(in_8);
        end
        if (q.size() == m_n || (fl && had && q.size() > 0)) begin
            m_word  = pack_q();
            m_valid = 1'b1;
            q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
        check("out_32", out_32, m_word);
        check("ready_in", {31'h0, ready_in}, {31'h0, (!m_valid || ready_out)});
    endtask

    task automatic send(input logic [7:0] b);
        in_8     = b;
        valid_in = 1'b1;
        tick();
    endtask

    task automatic idle();
        valid_in = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_out", out_32, 32'h0);
        check("rst_ready", {31'h0, ready_in}, 32'h1);
        q.delete();
        m_valid = 1'b0;
        m_word  = 32'h0;
        m_n     = 4;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        PCLK      = 2'b00;
        ENB       = 1'b1;
        in_8      = 8'h00;
        valid_in  = 1'b0;
        ready_out = 1'b1;
`ifdef EMPAQ_FLUSH_EN
        flush     = 1'b0;
`endif
        m_n = 4;
        reset = 1'b0;
        #2;
        do_reset();

        // 32-bit packing
        send(8'hAA); send(8'hBB); send(8'hCC);
        check("w32_early", {31'h0, valid_out}, 32'h0);
        send(8'hDD);
        check("w32", out_32, 32'hAABBCCDD);
        check("w32_vld", {31'h0, valid_out}, 32'h1);
        idle();

        // 16-bit packing, back-to-back
        PCLK = 2'b01;
        send(8'h12); send(8'h34);
        check("w16a", out_32, 32'h00001234);
        check("w16a_rdy", {31'h0, ready_in}, 32'h1);
        send(8'h56);
        send(8'h78);
        check("w16b", out_32, 32'h00005678);
        idle();

        // backpressure
        PCLK = 2'b00;
        ready_out = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("bp_word", out_32, 32'h01020304);
        check("bp_rdy", {31'h0, ready_in}, 32'h0);
        send(8'h05); send(8'h05);
        check("bp_hold", out_32, 32'h01020304);
        check("bp_hold_vld", {31'h0, valid_out}, 32'h1);
        ready_out = 1'b1;
        send(8'h05);
        check("bp_consumed", {31'h0, valid_out}, 32'h0);
        send(8'h06); send(8'h07); send(8'h08);
        check("bp_next", out_32, 32'h05060708);
        idle();

        // width change mid-word
        PCLK = 2'b00;
        send(8'hA1); send(8'hA2);
        PCLK = 2'b10;
        send(8'hA3);
        check("wc_pending", {31'h0, valid_out}, 32'h0);
        send(8'hA4);
        check("wc_word", out_32, 32'hA1A2A3A4);
        send(8'hB1);
        check("wc_b1", out_32, 32'h000000B1);
        send(8'hB2);
        check("wc_b2", out_32, 32'h000000B2);
        PCLK = 2'b11;
        send(8'hB3);
        check("wc_rsvd", out_32, 32'h000000B3);
        idle();

        // enable pause
        PCLK = 2'b00;
        send(8'hE1); send(8'hE2);
        ENB = 1'b0;
        send(8'hFF); send(8'hFF); send(8'hFF);
        ENB = 1'b1;
        send(8'hE3); send(8'hE4);
        check("enb_word", out_32, 32'hE1E2E3E4);
        idle();

        // reset mid-word
        send(8'hC1); send(8'hC2); send(8'hC3);
        do_reset();
        send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
        check("rst_fresh", out_32, 32'hD1D2D3D4);
        idle();

`ifdef EMPAQ_FLUSH_EN
        // flush of a partial word, then flush ignored while FULL
        PCLK = 2'b00;
        send(8'h11); send(8'h22);
        valid_in = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_word", out_32, 32'h11220000);
        check("flush_vld", {31'h0, valid_out}, 32'h1);
        ready_out = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_full", out_32, 32'h11220000);
        ready_out = 1'b1;
        idle();
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            PCLK      = 2'($urandom_range(0, 3));
            ENB       = ($urandom_range(0, 9) < 8);
            valid_in  = ($urandom_range(0, 9) < 7);
            ready_out = ($urandom_range(0, 9) < 6);
            in_8      = 8'($urandom);
`ifdef EMPAQ_FLUSH_EN
            flush     = ($urandom_range(0, 19) == 0);
`endif
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
